qs_test: RTL and testbench

Two-button LED sequencer for board bring-up. Takes two active-low push-buttons, synchronizes and debounces them, and drives a 4-bit LED bank in one of two display modes. btn2 advances the display by one step. btn1 toggles between a binary counter and a one-hot ring. It sits directly between the board button pins and the LED pins.

---
 rtl/qs_test.sv | 123 ++++++++++++
 tb/tb_qs_test.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/qs_test.sv
// rtl/qs_test.sv - two-button LED sequencer: synchronize, debounce, count or ring display
module qs_test #(
  parameter int DEBOUNCE = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn1,
  input  logic       btn2,
  output logic [3:0] led
);

  // Run-length counter width; holds values 0..DEBOUNCE-1 with headroom.
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  typedef enum logic {
    COUNT = 1'b0,
    RING  = 1'b1
  } mode_t;

  // Bit 0 is the mode button (btn1), bit 1 is the step button (btn2).
  // All level signals are active-low: 1 means released.
  logic [1:0]    btn_raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    db;
  logic [1:0]    db_q;
  logic [CW-1:0] cnt [2];
  logic [1:0]    press;

  mode_t         mode_q;
  mode_t         mode_d;
  logic [3:0]    led_d;

  assign btn_raw = {btn2, btn1};

  // Two-flop synchronizer; reset parks both stages at released.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 2'b11;
      sync2 <= 2'b11;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Debouncer: flip the debounced state after DEBOUNCE consecutive differing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      db <= 2'b11;
      for (int i = 0; i < 2; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != db[i]) begin
          if (cnt[i] == CNT_LAST) begin
            db[i]  <= ~db[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + CW'(1);
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  // Edge-detect register: previous debounced level, released after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_q <= 2'b11;
    end else begin
      db_q <= db;
    end
  end

  // One-cycle event on each debounced released-to-pressed transition only.
  assign press = db_q & ~db;

  // Mode state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= COUNT;
    end else begin
      mode_q <= mode_d;
    end
  end

  // Next-state logic: the mode button toggles between COUNT and RING.
  always_comb begin
    mode_d = mode_q;
    if (press[0]) begin
      mode_d = (mode_q == COUNT) ? RING : COUNT;
    end
  end

  // Output logic: mode press reloads the pattern and wins over a same-cycle step.
  always_comb begin
    led_d = led;
    if (press[0]) begin
      led_d = (mode_q == COUNT) ? 4'b0001 : 4'b0000;
    end else if (press[1]) begin
      if (mode_q == COUNT) begin
        led_d = led + 4'd1;
      end else begin
        led_d = {led[2:0], led[3]};
      end
    end
  end

  // LED register; driven straight from a flop so the pins never glitch.
  always_ff @(posedge clk) begin
    if (reset) begin
      led <= 4'b0000;
    end else begin
      led <= led_d;
    end
  end

endmodule

// File: tb/tb_qs_test.sv
// tb/tb_qs_test.sv - directed self-checking bench for qs_test
module tb_qs_test;

  logic       clk;
  logic       reset;
  logic       btn1;
  logic       btn2;
  logic [3:0] led;

  int n_checks;
  int n_pass;

  qs_test #(.DEBOUNCE(2)) dut (
    .clk   (clk),
    .reset (reset),
    .btn1  (btn1),
    .btn2  (btn2),
    .led   (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Press: low for 3 edges, then released for 50 edges.
  task automatic press2();
    btn2 = 1'b0;
    tick(3);
    btn2 = 1'b1;
    tick(50);
  endtask

  task automatic press1();
    btn1 = 1'b0;
    tick(3);
    btn1 = 1'b1;
    tick(50);
  endtask

  logic [3:0] exp_led;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    btn1     = 1'b1;
    btn2     = 1'b1;

    // Reset and idle
    tick(5);
    check("reset", led, 4'b0000);
    reset = 1'b0;
    tick(100);
    check("idle", led, 4'b0000);

    // Step sequence
    press2(); check("seq1", led, 4'b0001);
    press2(); check("seq2", led, 4'b0010);
    press1(); check("seq3_ring", led, 4'b0001);
    press2(); check("seq4", led, 4'b0010);
    press2(); check("seq5", led, 4'b0100);
    press2(); check("seq6", led, 4'b1000);
    press1(); check("seq7_count", led, 4'b0000);
    press2(); check("seq8", led, 4'b0001);

    // Back to COUNT with led=0000
    press1(); check("to_ring", led, 4'b0001);
    press1(); check("to_count", led, 4'b0000);

    // Count wrap: 17 presses
    for (int i = 1; i <= 17; i++) begin
      press2();
      exp_led = 4'(i);
      check($sformatf("count_%0d", i), led, exp_led);
    end

    // Ring wrap: 4 presses back to 0001
    press1(); check("ring_load", led, 4'b0001);
    press2(); check("ring1", led, 4'b0010);
    press2(); check("ring2", led, 4'b0100);
    press2(); check("ring3", led, 4'b1000);
    press2(); check("ring4", led, 4'b0001);
    press1(); check("count_load", led, 4'b0000);

    // Glitch rejection: single-cycle low pulse
    btn2 = 1'b0;
    tick(1);
    btn2 = 1'b1;
    tick(50);
    check("glitch", led, 4'b0000);

    // Latency and hold: first low sample at edge k, change at edge k+4
    btn2 = 1'b0;
    tick(4);
    check("lat_k3", led, 4'b0000);
    tick(1);
    check("lat_k4", led, 4'b0001);
    tick(195);
    check("hold", led, 4'b0001);
    btn2 = 1'b1;
    tick(50);
    check("hold_release", led, 4'b0001);

    // Simultaneous press from led=0011 in COUNT
    press2(); check("sim_pre2", led, 4'b0010);
    press2(); check("sim_pre3", led, 4'b0011);
    btn1 = 1'b0;
    btn2 = 1'b0;
    tick(3);
    btn1 = 1'b1;
    btn2 = 1'b1;
    tick(50);
    check("sim_both", led, 4'b0001);
    press2(); check("sim_ring1", led, 4'b0010);
    press2(); check("sim_ring2", led, 4'b0100);

    // Reset one edge before the debounced flip, btn2 kept low
    btn2 = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(1);
    check("mid_reset", led, 4'b0000);
    reset = 1'b0;
    tick(4);
    check("mid_k3", led, 4'b0000);
    tick(1);
    check("mid_k4", led, 4'b0001);
    btn2 = 1'b1;
    tick(50);
    press2(); check("mid_count", led, 4'b0010);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
